// File: rtl/hdr_ddr_bit_counter_if.sv
// hdr_ddr_bit_counter_if
// Groups the strobes into the HDR-DDR bit sequencer and its status outputs.
//   master : drives start / bit tick / abort / last-frame flag, observes status
//   slave  : the bit counter itself
// Signals:
//   i_bcnt_start      start of a transfer (pulse)
//   i_bcnt_bit_tick   one strobe per transferred bit
//   i_bcnt_abort      HDR restart/exit, drop the transfer (pulse)
//   i_fcnt_last_frame frame counter says the data word just ended was the last
//   o_cnt_bit_count   bit index within the current word
//   o_fcnt_en         pulse after each data word
//   o_bcnt_word_type  00 idle, 01 command, 10 data, 11 CRC
//   o_bcnt_preamble   index is 0 or 1
//   o_bcnt_parity     index is 18 or 19 (command/data only)
//   o_bcnt_busy       transfer in progress
//   o_bcnt_done       pulse after the final CRC bit
interface hdr_ddr_bit_counter_if #(
  parameter int CNT_W = 6
);
  logic             i_bcnt_start;
  logic             i_bcnt_bit_tick;
  logic             i_bcnt_abort;
  logic             i_fcnt_last_frame;
  logic [CNT_W-1:0] o_cnt_bit_count;
  logic             o_fcnt_en;
  logic [1:0]       o_bcnt_word_type;
  logic             o_bcnt_preamble;
  logic             o_bcnt_parity;
  logic             o_bcnt_busy;
  logic             o_bcnt_done;

  modport master (
    output i_bcnt_start, i_bcnt_bit_tick, i_bcnt_abort, i_fcnt_last_frame,
    input  o_cnt_bit_count, o_fcnt_en, o_bcnt_word_type, o_bcnt_preamble,
           o_bcnt_parity, o_bcnt_busy, o_bcnt_done
  );

  modport slave (
    input  i_bcnt_start, i_bcnt_bit_tick, i_bcnt_abort, i_fcnt_last_frame,
    output o_cnt_bit_count, o_fcnt_en, o_bcnt_word_type, o_bcnt_preamble,
           o_bcnt_parity, o_bcnt_busy, o_bcnt_done
  );
endinterface

// File: rtl/hdr_ddr_bit_counter.sv
// hdr_ddr_bit_counter
// Bit-position sequencer for HDR-DDR transfers: counts bit strobes inside
// each word and walks command word -> data words -> CRC word. Emits one
// o_fcnt_en pulse per data word for the frame counter and uses its
// last-frame flag to decide when the CRC word follows.
// Ports:
//   i_fcnt_clk    system clock
//   i_fcnt_rst_n  asynchronous active-low reset
//   bus           slave side of hdr_ddr_bit_counter_if (strobes in, status out)
module hdr_ddr_bit_counter #(
  parameter int WORD_BITS = 20,
  parameter int CRC_BITS  = 11,
  parameter int CNT_W     = 6
) (
  input  logic                        i_fcnt_clk,
  input  logic                        i_fcnt_rst_n,
  hdr_ddr_bit_counter_if.slave        bus
);

  // Encoding doubles as the word-type output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_DATA = 2'b10,
    ST_CRC  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_BITS - 1);
  localparam logic [CNT_W-1:0] PARITY_LO  = CNT_W'(WORD_BITS - 2);
  localparam logic [CNT_W-1:0] PREAMB_END = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fcnt_en_q, fcnt_en_d;
  logic             done_q, done_d;

  always_ff @(posedge i_fcnt_clk or negedge i_fcnt_rst_n) begin
    if (!i_fcnt_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fcnt_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_en_q <= fcnt_en_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_en_d = 1'b0;
    done_d    = 1'b0;

    if (bus.i_bcnt_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A tick coinciding with start is not counted.
          if (bus.i_bcnt_start) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (bus.i_bcnt_bit_tick) begin
            if (cnt_q == WORD_LAST) begin
              cnt_d   = '0;
              state_d = ST_DATA;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (bus.i_bcnt_bit_tick) begin
            if (cnt_q == WORD_LAST) begin
              cnt_d     = '0;
              fcnt_en_d = 1'b1;
              // Last-frame flag is only meaningful on the word-ending tick.
              state_d   = bus.i_fcnt_last_frame ? ST_CRC : ST_DATA;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_CRC: begin
          if (bus.i_bcnt_bit_tick) begin
            if (cnt_q == CRC_LAST) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Status decoded straight from flops, so they are glitch-free and follow
  // the index with no extra latency.
  assign bus.o_cnt_bit_count  = cnt_q;
  assign bus.o_fcnt_en        = fcnt_en_q;
  assign bus.o_bcnt_done      = done_q;
  assign bus.o_bcnt_word_type = state_q;
  assign bus.o_bcnt_busy      = (state_q != ST_IDLE);
  assign bus.o_bcnt_preamble  = (state_q != ST_IDLE) && (cnt_q < PREAMB_END);
  assign bus.o_bcnt_parity    = ((state_q == ST_CMD) || (state_q == ST_DATA)) &&
                                (cnt_q >= PARITY_LO);

endmodule

// File: tb/tb_hdr_ddr_bit_counter.sv
module tb_hdr_ddr_bit_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  hdr_ddr_bit_counter_if #(.CNT_W(6)) bus ();

  hdr_ddr_bit_counter #(
    .WORD_BITS(20),
    .CRC_BITS (11),
    .CNT_W    (6)
  ) dut (
    .i_fcnt_clk  (clk),
    .i_fcnt_rst_n(rst_n),
    .bus         (bus)
  );

  // Pulse counters sample the registered outputs on the active edge,
  // i.e. the value held during the preceding cycle.
  always @(posedge clk) begin
    if (bus.o_fcnt_en)   en_cnt++;
    if (bus.o_bcnt_done) done_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns at the following negedge.
  task automatic step(input logic s, input logic t, input logic a, input logic l);
    bus.i_bcnt_start      = s;
    bus.i_bcnt_bit_tick   = t;
    bus.i_bcnt_abort      = a;
    bus.i_fcnt_last_frame = l;
    @(posedge clk);
    @(negedge clk);
    bus.i_bcnt_start      = 1'b0;
    bus.i_bcnt_bit_tick   = 1'b0;
    bus.i_bcnt_abort      = 1'b0;
    bus.i_fcnt_last_frame = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"},   32'(bus.o_cnt_bit_count), 0);
    chk({tag, "_en"},    32'(bus.o_fcnt_en), 0);
    chk({tag, "_type"},  32'(bus.o_bcnt_word_type), 0);
    chk({tag, "_pre"},   32'(bus.o_bcnt_preamble), 0);
    chk({tag, "_par"},   32'(bus.o_bcnt_parity), 0);
    chk({tag, "_busy"},  32'(bus.o_bcnt_busy), 0);
    chk({tag, "_done"},  32'(bus.o_bcnt_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, done0, ticks;
    bit seen;
    bus.i_bcnt_start      = 1'b0;
    bus.i_bcnt_bit_tick   = 1'b0;
    bus.i_bcnt_abort      = 1'b0;
    bus.i_fcnt_last_frame = 1'b0;

    // Power-on reset values.
    @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;

    // Ticks without start are ignored.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("idle_tick_cnt", 32'(bus.o_cnt_bit_count), 0);
    chk("idle_tick_busy", 32'(bus.o_bcnt_busy), 0);

    // Start together with a tick: tick not counted.
    step(1, 1, 0, 0);
    chk("start_cnt", 32'(bus.o_cnt_bit_count), 0);
    chk("start_type", 32'(bus.o_bcnt_word_type), 1);
    chk("start_busy", 32'(bus.o_bcnt_busy), 1);
    chk("start_pre", 32'(bus.o_bcnt_preamble), 1);

    // Command word: index 1..19 then wrap into DATA with no frame enable.
    for (int k = 1; k < 20; k++) begin
      step(0, 1, 0, 0);
      chk("cmd_cnt", 32'(bus.o_cnt_bit_count), k);
      chk("cmd_pre", 32'(bus.o_bcnt_preamble), (k < 2) ? 1 : 0);
      chk("cmd_par", 32'(bus.o_bcnt_parity), (k >= 18) ? 1 : 0);
      chk("cmd_en", 32'(bus.o_fcnt_en), 0);
    end
    step(0, 1, 0, 0);
    chk("cmd_end_cnt", 32'(bus.o_cnt_bit_count), 0);
    chk("cmd_end_type", 32'(bus.o_bcnt_word_type), 2);
    chk("cmd_end_en", 32'(bus.o_fcnt_en), 0);

    // Data word 1, last_frame=0 -> stay in DATA.
    for (int k = 0; k < 19; k++) step(0, 1, 0, 0);
    chk("d1_cnt19", 32'(bus.o_cnt_bit_count), 19);
    chk("d1_par", 32'(bus.o_bcnt_parity), 1);
    step(0, 1, 0, 0);
    chk("d1_en", 32'(bus.o_fcnt_en), 1);
    chk("d1_type", 32'(bus.o_bcnt_word_type), 2);
    chk("d1_cnt", 32'(bus.o_cnt_bit_count), 0);
    step(0, 0, 0, 0);
    chk("d1_en_width", 32'(bus.o_fcnt_en), 0);

    // Data word 2, last_frame=1 -> CRC.
    for (int k = 0; k < 19; k++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("d2_en", 32'(bus.o_fcnt_en), 1);
    chk("d2_type", 32'(bus.o_bcnt_word_type), 3);
    chk("crc_pre", 32'(bus.o_bcnt_preamble), 1);

    // CRC word: 11 bits, parity never asserted.
    for (int k = 1; k < 11; k++) begin
      step(0, 1, 0, 0);
      chk("crc_cnt", 32'(bus.o_cnt_bit_count), k);
      chk("crc_par", 32'(bus.o_bcnt_parity), 0);
      chk("crc_done_early", 32'(bus.o_bcnt_done), 0);
    end
    step(0, 1, 0, 0);
    chk("crc_done", 32'(bus.o_bcnt_done), 1);
    chk("crc_idle_type", 32'(bus.o_bcnt_word_type), 0);
    chk("crc_idle_busy", 32'(bus.o_bcnt_busy), 0);
    chk("crc_idle_cnt", 32'(bus.o_cnt_bit_count), 0);
    step(0, 0, 0, 0);
    chk("done_width", 32'(bus.o_bcnt_done), 0);

    // Abort at data bit 7.
    step(1, 0, 0, 0);
    for (int k = 0; k < 27; k++) step(0, 1, 0, 0);
    chk("pre_abort_cnt", 32'(bus.o_cnt_bit_count), 7);
    chk("pre_abort_type", 32'(bus.o_bcnt_word_type), 2);
    en0 = en_cnt;
    done0 = done_cnt;
    step(0, 1, 1, 1);
    chk("abort_type", 32'(bus.o_bcnt_word_type), 0);
    chk("abort_cnt", 32'(bus.o_cnt_bit_count), 0);
    chk("abort_busy", 32'(bus.o_bcnt_busy), 0);
    for (int k = 0; k < 25; k++) step(0, 1, 0, 1);
    chk("abort_no_en", en_cnt, en0);
    chk("abort_no_done", done_cnt, done0);

    // Second start during CMD bit 5 ignored.
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    chk("cmd5_cnt", 32'(bus.o_cnt_bit_count), 5);
    step(1, 1, 0, 0);
    chk("restart_ign_cnt", 32'(bus.o_cnt_bit_count), 6);
    chk("restart_ign_type", 32'(bus.o_bcnt_word_type), 1);

    // Asynchronous reset mid-word.
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("post_rst_cnt", 32'(bus.o_cnt_bit_count), 0);
    chk("post_rst_busy", 32'(bus.o_bcnt_busy), 0);

    // Full transfer with a tick every cycle: 1 cmd, 3 data, CRC.
    step(1, 0, 0, 0);
    en0 = en_cnt;
    done0 = done_cnt;
    ticks = 0;
    seen = 0;
    while (!seen && ticks < 200) begin
      ticks++;
      step(0, 1, 0, (ticks == 80) ? 1'b1 : 1'b0);
      if (bus.o_bcnt_done) seen = 1;
    end
    chk("full_done_seen", seen ? 1 : 0, 1);
    chk("full_ticks", ticks, 91);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("full_en_pulses", en_cnt - en0, 3);
    chk("full_done_pulses", done_cnt - done0, 1);
    chk("full_idle", 32'(bus.o_bcnt_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdr_ddr_bit_counter.md
# hdr_ddr_bit_counter

Bit-position sequencer for HDR-DDR transfers in the CCC handler. It counts bit strobes inside each 20-bit HDR-DDR word and tracks the word sequence: command word, then data words, then CRC word. It supplies the bit index (`o_cnt_bit_count`) and a one-pulse-per-data-word enable (`o_fcnt_en`) to the downstream frame counter. It uses that counter's last-frame flag to decide when the CRC word follows.

## Interface
Parameters:
- `WORD_BITS`, 20: bits per command/data word (2 preamble + 16 payload + 2 parity).
- `CRC_BITS`, 11: bits in the CRC word (2 preamble + 4 token + 5 CRC).
- `CNT_W`, 6: width of the bit index.

Ports:
- `i_fcnt_clk`  in  1  system clock.
- `i_fcnt_rst_n`  in  1  reset, asynchronous, active-low.
- `i_bcnt_start`  in  1  one-cycle pulse; begins a transfer at bit 0 of the command word.
- `i_bcnt_bit_tick`  in  1  one-cycle strobe per bit transferred (both SCL edges in DDR).
- `i_bcnt_abort`  in  1  one-cycle pulse; HDR restart/exit detected, transfer dropped.
- `i_fcnt_last_frame`  in  1  from frame counter; high means the data word just ended was the last one.
- `o_cnt_bit_count`  out  CNT_W  current bit index within the word.
- `o_fcnt_en`  out  1  one-cycle pulse at the end of each data word.
- `o_bcnt_word_type`  out  2  00 idle, 01 command, 10 data, 11 CRC.
- `o_bcnt_preamble`  out  1  high while the bit index is 0 or 1 (all word types).
- `o_bcnt_parity`  out  1  high while the bit index is 18 or 19 (command/data words only).
- `o_bcnt_busy`  out  1  high in any state other than IDLE.
- `o_bcnt_done`  out  1  one-cycle pulse after the final CRC bit.

## Operation
- States: IDLE, CMD, DATA, CRC.
- IDLE:
  - `i_bcnt_start` → CMD with the bit index at 0.
  - Ticks are ignored.
- Every state except IDLE: each tick increments the bit index. On the last bit of the word (index `WORD_BITS-1`, or `CRC_BITS-1` in CRC) the index wraps to 0 and the word ends.
- CMD: the word ends → DATA. No `o_fcnt_en` pulse.
- DATA: the word ends → `o_fcnt_en` pulses. `i_fcnt_last_frame` is sampled on the ending tick:
  - 1 → CRC.
  - 0 → stay in DATA.
- CRC: the word ends → `o_bcnt_done` pulses, then IDLE.
- `i_bcnt_abort` in any state → IDLE and the bit index clears. No `o_fcnt_en` or `o_bcnt_done` pulse follows.
- Arithmetic: the bit index is unsigned `CNT_W` bits and never exceeds the length of the current word minus 1. Words never carry across a boundary.

## Timing
- Reset values: `o_cnt_bit_count`=0, `o_fcnt_en`=0, `o_bcnt_word_type`=00, `o_bcnt_preamble`=0, `o_bcnt_parity`=0, `o_bcnt_busy`=0, `o_bcnt_done`=0. State = IDLE.
- All outputs are registered. Each output reflects the tick consumed on the previous rising edge, so latency is 1 cycle from tick to the new index.
- `o_fcnt_en` and `o_bcnt_done` are exactly 1 cycle wide and appear in the cycle after the word-ending tick.
- `o_bcnt_preamble` and `o_bcnt_parity` are decoded from the registered index and state. Both are 0 in IDLE.
- Precedence in one cycle: reset > abort > start > tick.
  - A start arriving together with a tick in IDLE: the tick is not counted.
  - A start while busy is ignored.
- Reset asserted mid-word: all outputs are forced to their reset values immediately (asynchronously). Operation resumes only on the next start.
- Back-to-back ticks on consecutive cycles are supported. No minimum gap is required between ticks.

## Test plan
- Reset: assert `i_fcnt_rst_n`=0 mid-stream → all outputs at reset values. After release, 5 ticks with no start → index stays 0, busy stays 0.
- Command word: start, then 20 ticks → index runs 0..19 then 0. `word_type` goes 01→10, no `o_fcnt_en` pulse. Preamble is high for indexes 0–1, parity for 18–19.
- Two data words: `i_fcnt_last_frame`=0 on the first ending tick and =1 on the second → two `o_fcnt_en` pulses. Then CRC (`word_type`=11); 11 ticks later one `o_bcnt_done` pulse, then IDLE.
- Abort at data bit 7 → next cycle state is IDLE, index is 0, busy is 0. No `o_fcnt_en` or `o_bcnt_done` pulse; a later start runs a fresh transfer normally.
- Start and tick in the same cycle → index is 0 afterwards. A second start during CMD bit 5 is ignored and the index continues at 6.
- Ticks on every cycle through a full transfer (1 command, 3 data, CRC) → exactly 3 `o_fcnt_en` pulses and 1 `o_bcnt_done` pulse, with the total tick count equal to 20×4+11=91.
